// File: rtl/commit_chk_pkg.sv
// Shared types for the commit stream checker: status encoding, entry layout, index sizing.
package commit_chk_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MISMATCH = 2'd1,
    ST_OVERFLOW = 2'd2,
    ST_TIMEOUT  = 2'd3
  } status_e;

  localparam int DEF_TAG_WIDTH  = 10;
  localparam int DEF_DATA_WIDTH = 32;

  typedef struct packed {
    logic [DEF_TAG_WIDTH-1:0]  tag;
    logic [DEF_DATA_WIDTH-1:0] data;
  } entry_t;

  // Channel index needs at least one bit even for a single channel.
  function automatic int ch_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/commit_fifo.sv
// Small synchronous FIFO; head is registered state, so a push is visible one edge later.
// A push to a full FIFO is accepted only when the same cycle pops; otherwise it is dropped.
module commit_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/commit_stream_checker.sv
// Lockstep checker: pairs REF and DUT commits per channel through skew FIFOs and compares them.
// Sticky status with first-error capture; no backpressure, commits are always accepted or flagged.
module commit_stream_checker
  import commit_chk_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               CLEAR,
  input  logic [NUM_CH-1:0]                  ref_valid,
  input  logic [NUM_CH*TAG_WIDTH-1:0]        ref_tag,
  input  logic [NUM_CH*DATA_WIDTH-1:0]       ref_data,
  input  logic [NUM_CH-1:0]                  dut_valid,
  input  logic [NUM_CH*TAG_WIDTH-1:0]        dut_tag,
  input  logic [NUM_CH*DATA_WIDTH-1:0]       dut_data,
  output logic [1:0]                         status,
  output logic                               err,
  output logic [ch_idx_width(NUM_CH)-1:0]    err_ch,
  output logic [CNT_WIDTH-1:0]               err_idx,
  output logic [TAG_WIDTH-1:0]               err_exp_tag,
  output logic [TAG_WIDTH-1:0]               err_act_tag,
  output logic [DATA_WIDTH-1:0]              err_exp_data,
  output logic [DATA_WIDTH-1:0]              err_act_data,
  output logic [CNT_WIDTH-1:0]               match_count,
  output logic [NUM_CH-1:0]                  pending
);

  localparam int CHW = ch_idx_width(NUM_CH);
  localparam int EW  = TAG_WIDTH + DATA_WIDTH;
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } ch_entry_t;

  ch_entry_t             ref_head [NUM_CH];
  ch_entry_t             dut_head [NUM_CH];
  logic [NUM_CH-1:0]     ref_full, ref_empty, dut_full, dut_empty;
  logic [NUM_CH-1:0]     cmp, hit, miss, ovf, one_side, tmo_hit;
  logic [CNT_WIDTH-1:0]  ch_idx  [NUM_CH];
  logic [TW-1:0]         tmo_cnt [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_entry_t ref_in;
    ch_entry_t dut_in;

    assign ref_in.tag  = ref_tag [g*TAG_WIDTH  +: TAG_WIDTH];
    assign ref_in.data = ref_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign dut_in.tag  = dut_tag [g*TAG_WIDTH  +: TAG_WIDTH];
    assign dut_in.data = dut_data[g*DATA_WIDTH +: DATA_WIDTH];

    commit_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_ref_fifo (
      .clk       (CLK),
      .rst       (RESET),
      .clear     (CLEAR),
      .push      (ref_valid[g]),
      .push_data (ref_in),
      .pop       (cmp[g]),
      .head      (ref_head[g]),
      .full      (ref_full[g]),
      .empty     (ref_empty[g])
    );

    commit_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_dut_fifo (
      .clk       (CLK),
      .rst       (RESET),
      .clear     (CLEAR),
      .push      (dut_valid[g]),
      .push_data (dut_in),
      .pop       (cmp[g]),
      .head      (dut_head[g]),
      .full      (dut_full[g]),
      .empty     (dut_empty[g])
    );

    // Both heads present means compare and pop both on this edge.
    assign cmp[g]      = ~ref_empty[g] & ~dut_empty[g];
    assign hit[g]      = cmp[g] & (ref_head[g] == dut_head[g]);
    assign miss[g]     = cmp[g] & (ref_head[g] != dut_head[g]);
    assign ovf[g]      = (ref_valid[g] & ref_full[g] & ~cmp[g]) |
                         (dut_valid[g] & dut_full[g] & ~cmp[g]);
    assign one_side[g] = ref_empty[g] ^ dut_empty[g];
    assign tmo_hit[g]  = (TIMEOUT != 0) & one_side[g] & (tmo_cnt[g] == TMO_LAST);
    assign pending[g]  = ~ref_empty[g] | ~dut_empty[g];
  end

  // Error selection: mismatch beats overflow beats timeout, lowest channel within a class.
  status_e                sel_state;
  logic                   sel_found;
  logic [CHW-1:0]         sel_ch;
  logic [CNT_WIDTH-1:0]   sel_idx;
  logic [TAG_WIDTH-1:0]   sel_exp_tag, sel_act_tag;
  logic [DATA_WIDTH-1:0]  sel_exp_data, sel_act_data;
  logic [CNT_WIDTH-1:0]   match_inc;

  always_comb begin
    sel_state    = ST_RUN;
    sel_found    = 1'b0;
    sel_ch       = '0;
    sel_idx      = '0;
    sel_exp_tag  = '0;
    sel_act_tag  = '0;
    sel_exp_data = '0;
    sel_act_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!sel_found && miss[i]) begin
        sel_found    = 1'b1;
        sel_state    = ST_MISMATCH;
        sel_ch       = CHW'(i);
        sel_idx      = ch_idx[i];
        sel_exp_tag  = ref_head[i].tag;
        sel_act_tag  = dut_head[i].tag;
        sel_exp_data = ref_head[i].data;
        sel_act_data = dut_head[i].data;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!sel_found && ovf[i]) begin
        sel_found = 1'b1;
        sel_state = ST_OVERFLOW;
        sel_ch    = CHW'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!sel_found && tmo_hit[i]) begin
        sel_found = 1'b1;
        sel_state = ST_TIMEOUT;
        sel_ch    = CHW'(i);
      end
    end
  end

  always_comb begin
    match_inc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      match_inc = match_inc + CNT_WIDTH'(hit[i]);
    end
  end

  // Status FSM: RUN moves to the selected error, error states hold until flushed.
  status_e state_q, state_d;
  logic    cap_en;

  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    if (state_q == ST_RUN && sel_state != ST_RUN) begin
      state_d = sel_state;
      cap_en  = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_RUN;
    end else if (CLEAR) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign status = state_q;
  assign err    = (state_q != ST_RUN);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_ch       <= '0;
      err_idx      <= '0;
      err_exp_tag  <= '0;
      err_act_tag  <= '0;
      err_exp_data <= '0;
      err_act_data <= '0;
    end else if (CLEAR) begin
      err_ch       <= '0;
      err_idx      <= '0;
      err_exp_tag  <= '0;
      err_act_tag  <= '0;
      err_exp_data <= '0;
      err_act_data <= '0;
    end else if (cap_en) begin
      err_ch       <= sel_ch;
      err_idx      <= sel_idx;
      err_exp_tag  <= sel_exp_tag;
      err_act_tag  <= sel_act_tag;
      err_exp_data <= sel_exp_data;
      err_act_data <= sel_act_data;
    end
  end

  // Compare indices and stall timers keep running in error states so streams drain.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      match_count <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_idx[i]  <= '0;
        tmo_cnt[i] <= '0;
      end
    end else if (CLEAR) begin
      match_count <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_idx[i]  <= '0;
        tmo_cnt[i] <= '0;
      end
    end else begin
      match_count <= match_count + match_inc;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cmp[i]) ch_idx[i] <= ch_idx[i] + 1'b1;
        if (!one_side[i]) begin
          tmo_cnt[i] <= '0;
        end else if (tmo_cnt[i] != TMO_MAX) begin
          tmo_cnt[i] <= tmo_cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_commit_stream_checker.sv
// Directed bench for commit_stream_checker: a cycle table for streaming matches plus
// hand sequences for capture freeze, error priority, overflow, timeout and CLEAR.
module tb_commit_stream_checker;

  localparam int NCH = 2;
  localparam int TW  = 10;
  localparam int DW  = 32;

  logic               CLK = 1'b0;
  logic               RESET;
  logic               CLEAR;
  logic [NCH-1:0]     ref_valid, dut_valid;
  logic [NCH*TW-1:0]  ref_tag, dut_tag;
  logic [NCH*DW-1:0]  ref_data, dut_data;
  logic [1:0]         status;
  logic               err;
  logic [0:0]         err_ch;
  logic [31:0]        err_idx;
  logic [TW-1:0]      err_exp_tag, err_act_tag;
  logic [DW-1:0]      err_exp_data, err_act_data;
  logic [31:0]        match_count;
  logic [NCH-1:0]     pending;

  int total = 0;
  int bad   = 0;

  commit_stream_checker dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .CLEAR        (CLEAR),
    .ref_valid    (ref_valid),
    .ref_tag      (ref_tag),
    .ref_data     (ref_data),
    .dut_valid    (dut_valid),
    .dut_tag      (dut_tag),
    .dut_data     (dut_data),
    .status       (status),
    .err          (err),
    .err_ch       (err_ch),
    .err_idx      (err_idx),
    .err_exp_tag  (err_exp_tag),
    .err_act_tag  (err_act_tag),
    .err_exp_data (err_exp_data),
    .err_act_data (err_act_data),
    .match_count  (match_count),
    .pending      (pending)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  rv;
    logic [9:0]  rtag;
    logic [31:0] rdat;
    logic [1:0]  dv;
    logic [9:0]  dtag;
    logic [31:0] ddat;
    logic [1:0]  e_status;
    logic [31:0] e_match;
    logic [1:0]  e_pend;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    ref_valid = '0;
    dut_valid = '0;
    CLEAR     = 1'b0;
  endtask

  // One clock edge; outputs are then stable for checking and inputs return to idle.
  task automatic cyc();
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic push_ref(input int ch, input logic [9:0] t, input logic [31:0] d);
    ref_valid[ch]          = 1'b1;
    ref_tag[ch*TW +: TW]   = t;
    ref_data[ch*DW +: DW]  = d;
  endtask

  task automatic push_dut(input int ch, input logic [9:0] t, input logic [31:0] d);
    dut_valid[ch]          = 1'b1;
    dut_tag[ch*TW +: TW]   = t;
    dut_data[ch*DW +: DW]  = d;
  endtask

  task automatic do_clear();
    CLEAR = 1'b1;
    cyc();
  endtask

  initial begin
    //            rv     rtag   rdat      dv     dtag   ddat      st    match  pend
    vecs[0]  = '{2'b01, 10'd5, 32'h1,    2'b00, 10'd0, 32'h0,    2'd0, 32'd0, 2'b01};
    vecs[1]  = '{2'b00, 10'd0, 32'h0,    2'b00, 10'd0, 32'h0,    2'd0, 32'd0, 2'b01};
    vecs[2]  = '{2'b00, 10'd0, 32'h0,    2'b00, 10'd0, 32'h0,    2'd0, 32'd0, 2'b01};
    vecs[3]  = '{2'b00, 10'd0, 32'h0,    2'b01, 10'd5, 32'h1,    2'd0, 32'd0, 2'b01};
    vecs[4]  = '{2'b00, 10'd0, 32'h0,    2'b00, 10'd0, 32'h0,    2'd0, 32'd1, 2'b00};
    vecs[5]  = '{2'b11, 10'd7, 32'h70,   2'b11, 10'd7, 32'h70,   2'd0, 32'd1, 2'b11};
    vecs[6]  = '{2'b10, 10'd3, 32'h33,   2'b00, 10'd0, 32'h0,    2'd0, 32'd3, 2'b10};
    vecs[7]  = '{2'b00, 10'd0, 32'h0,    2'b10, 10'd3, 32'h33,   2'd0, 32'd3, 2'b10};
    vecs[8]  = '{2'b00, 10'd0, 32'h0,    2'b00, 10'd0, 32'h0,    2'd0, 32'd4, 2'b00};
    vecs[9]  = '{2'b01, 10'd1, 32'h11,   2'b01, 10'd1, 32'h11,   2'd0, 32'd4, 2'b01};
    vecs[10] = '{2'b01, 10'd2, 32'h22,   2'b01, 10'd2, 32'h22,   2'd0, 32'd5, 2'b01};
    vecs[11] = '{2'b00, 10'd0, 32'h0,    2'b00, 10'd0, 32'h0,    2'd0, 32'd6, 2'b00};

    RESET    = 1'b1;
    idle();
    ref_tag  = '0;
    ref_data = '0;
    dut_tag  = '0;
    dut_data = '0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;

    // Reset state and idle stability
    chk("rst_status", status, 2'd0);
    chk("rst_err_ch", err_ch, 1'b0);
    chk("rst_err_idx", err_idx, 32'd0);
    chk("rst_exp_data", err_exp_data, 32'd0);
    chk("rst_act_tag", err_act_tag, 10'd0);
    for (int c = 0; c < 20; c++) begin
      cyc();
      chk($sformatf("idle%0d_status", c), status, 2'd0);
      chk($sformatf("idle%0d_err", c), err, 1'b0);
      chk($sformatf("idle%0d_match", c), match_count, 32'd0);
      chk($sformatf("idle%0d_pend", c), pending, 2'b00);
    end

    // Streaming table, includes the 3-cycle skewed match on ch0
    for (int i = 0; i < 12; i++) begin
      ref_valid = vecs[i].rv;
      ref_tag   = {2{vecs[i].rtag}};
      ref_data  = {2{vecs[i].rdat}};
      dut_valid = vecs[i].dv;
      dut_tag   = {2{vecs[i].dtag}};
      dut_data  = {2{vecs[i].ddat}};
      cyc();
      chk($sformatf("vec%0d_status", i), status, vecs[i].e_status);
      chk($sformatf("vec%0d_match", i), match_count, vecs[i].e_match);
      chk($sformatf("vec%0d_pend", i), pending, vecs[i].e_pend);
    end

    // Mismatch on the third ch0 compare, then capture must stay frozen
    do_clear();
    chk("clr1_match", match_count, 32'd0);
    push_ref(0, 10'd1, 32'h10); push_dut(0, 10'd1, 32'h10); cyc();
    push_ref(0, 10'd2, 32'h20); push_dut(0, 10'd2, 32'h20); cyc();
    push_ref(0, 10'd5, 32'h8);  push_dut(0, 10'd5, 32'h9);  cyc();
    chk("mm_status_before", status, 2'd0);
    cyc();
    chk("mm_status", status, 2'd1);
    chk("mm_err", err, 1'b1);
    chk("mm_err_ch", err_ch, 1'b0);
    chk("mm_err_idx", err_idx, 32'd2);
    chk("mm_exp_tag", err_exp_tag, 10'd5);
    chk("mm_act_tag", err_act_tag, 10'd5);
    chk("mm_exp_data", err_exp_data, 32'h8);
    chk("mm_act_data", err_act_data, 32'h9);
    chk("mm_match", match_count, 32'd2);
    push_ref(1, 10'd9, 32'h1); push_dut(1, 10'd9, 32'h2); cyc();
    push_ref(0, 10'd4, 32'h4); push_dut(0, 10'd4, 32'h4); cyc();
    cyc();
    chk("frz_status", status, 2'd1);
    chk("frz_err_ch", err_ch, 1'b0);
    chk("frz_err_idx", err_idx, 32'd2);
    chk("frz_act_data", err_act_data, 32'h9);
    chk("frz_match", match_count, 32'd3);
    chk("frz_pend", pending, 2'b00);

    // Same-edge mismatches on both channels: ch0 wins
    do_clear();
    chk("clr2_status", status, 2'd0);
    push_ref(0, 10'd1, 32'h1); push_dut(0, 10'd1, 32'h2);
    push_ref(1, 10'd2, 32'h3); push_dut(1, 10'd2, 32'h4);
    cyc();
    cyc();
    chk("dual_status", status, 2'd1);
    chk("dual_err_ch", err_ch, 1'b0);
    chk("dual_exp_data", err_exp_data, 32'h1);
    chk("dual_act_data", err_act_data, 32'h2);

    // ch0 overflow and ch1 mismatch on the same edge: mismatch wins
    do_clear();
    for (int k = 0; k < 4; k++) begin
      push_ref(0, 10'(k), 32'(k));
      if (k == 3) begin
        push_ref(1, 10'd3, 32'h30);
        push_dut(1, 10'd3, 32'h31);
      end
      cyc();
    end
    chk("pri_status_before", status, 2'd0);
    push_ref(0, 10'd9, 32'h9); cyc();
    chk("pri_status", status, 2'd1);
    chk("pri_err_ch", err_ch, 1'b1);
    chk("pri_exp_data", err_exp_data, 32'h30);
    chk("pri_act_data", err_act_data, 32'h31);

    // Overflow boundary on ch1
    do_clear();
    for (int k = 0; k < 4; k++) begin
      push_ref(1, 10'(k), 32'(k));
      cyc();
    end
    chk("ovf_full_status", status, 2'd0);
    chk("ovf_full_pend", pending, 2'b10);
    push_ref(1, 10'd4, 32'h4); cyc();
    chk("ovf_status", status, 2'd2);
    chk("ovf_err_ch", err_ch, 1'b1);
    chk("ovf_err_idx", err_idx, 32'd0);

    // Push into a full FIFO while it pops is legal
    do_clear();
    for (int k = 0; k < 4; k++) begin
      push_ref(1, 10'(k + 1), 32'(k + 1));
      if (k == 3) push_dut(1, 10'd1, 32'h1);
      cyc();
    end
    push_ref(1, 10'd5, 32'h5); cyc();
    chk("ovfpop_status", status, 2'd0);
    chk("ovfpop_match", match_count, 32'd1);
    chk("ovfpop_pend", pending, 2'b10);

    // Timeout: ch0 REF alone, ch1 matched pair alongside
    do_clear();
    push_ref(0, 10'd4, 32'h44);
    push_ref(1, 10'd6, 32'h66); push_dut(1, 10'd6, 32'h66);
    cyc();
    for (int k = 1; k < 16; k++) begin
      cyc();
      chk($sformatf("tmo_wait%0d", k), status, 2'd0);
    end
    cyc();
    chk("tmo_status", status, 2'd3);
    chk("tmo_err_ch", err_ch, 1'b0);
    chk("tmo_match", match_count, 32'd1);
    chk("tmo_pend", pending, 2'b01);

    // CLEAR wins over a push in the same cycle
    CLEAR = 1'b1;
    push_ref(0, 10'd7, 32'h77);
    push_dut(1, 10'd8, 32'h88);
    cyc();
    chk("clr_status", status, 2'd0);
    chk("clr_err", err, 1'b0);
    chk("clr_pend", pending, 2'b00);
    chk("clr_match", match_count, 32'd0);
    cyc();
    chk("clr_drop_pend", pending, 2'b00);

    // Asynchronous RESET mid-stream discards entries and error state at once
    for (int k = 0; k < 5; k++) begin
      push_ref(1, 10'(k), 32'(k));
      cyc();
    end
    chk("arst_pre_status", status, 2'd2);
    #2 RESET = 1'b1;
    #1;
    chk("arst_status", status, 2'd0);
    chk("arst_pend", pending, 2'b00);
    chk("arst_err_ch", err_ch, 1'b0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    cyc();
    chk("arst_after_pend", pending, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
